// File: rtl/riscv_data_mem_if.sv
// Request/response bus between the core's MEM stage and riscv_data_mem.
// The master drives the request fields; the memory drives req_ready and
// the pipelined response.
interface riscv_data_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/riscv_data_mem.sv
// riscv_data_mem: single-port data memory for the load/store path.
// Byte/half/word(/double) accesses with byte-lane writes, sign/zero
// extended loads, alignment/range/size error reporting and a 1- or
// 2-cycle pipelined response.
//
// Optional build macro RISCV_DATA_MEM_CLEAR_EN: when defined, the memory
// is zero-filled one word per cycle after reset before req_ready rises.
//
// FSM states:
//   state    | meaning
//   ST_RESET | just out of reset, not accepting requests
//   ST_CLEAR | zero-filling the array (clear build only)
//   ST_READY | accepting requests until the next reset
module riscv_data_mem #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_DEPTH    = 16384,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  riscv_data_mem_if.slave  bus
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t              state;
  logic                ready_q;
  logic [IDX_W-1:0]    clr_cnt;

  logic                accept;
  logic [IDX_W-1:0]    idx;
  logic [LSB-1:0]      off;
  logic                misalign;
  logic                range_err;
  logic                size_err;
  logic                req_err;
  logic [NB-1:0]       lane_mask;
  logic [NB-1:0]       byte_en;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic                wr_en;
  logic                rd_en;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  logic                p1_valid;
  logic                p1_load;
  logic                p1_err;
  logic [LSB-1:0]      p1_off;
  logic [1:0]          p1_size;
  logic                p1_uns;

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ext;
  logic [DATA_WIDTH-1:0] load_data;

  assign accept = bus.req_valid && ready_q;
  assign idx    = bus.req_addr[LSB +: IDX_W];
  assign off    = bus.req_addr[LSB-1:0];

  // Alignment check against the natural boundary of the access size.
  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = (bus.req_addr[1:0] != 2'b00);
      2'b11:   misalign = (bus.req_addr[2:0] != 3'b000);
      default: misalign = 1'b0;
    endcase
  end

  // Any address bit above the word index means the word lies past MEM_DEPTH.
  assign range_err = ((bus.req_addr >> (LSB + IDX_W)) != '0);
  assign size_err  = (bus.req_size == 2'b11) && (DATA_WIDTH == 32);
  assign req_err   = misalign || range_err || size_err;

  // Lanes covered by the access, before shifting to the byte offset.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i] = (i < (1 << bus.req_size));
    end
  end

  assign byte_en  = lane_mask << off;
  assign wdata_sh = bus.req_wdata << {off, 3'b000};
  assign wr_en    = accept && bus.req_we && !req_err;
  assign rd_en    = accept && !bus.req_we && !req_err;

  // Sequencing FSM; req_ready is a registered output of this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RESET;
      ready_q <= 1'b0;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_RESET: begin
`ifdef RISCV_DATA_MEM_CLEAR_EN
          state   <= ST_CLEAR;
          clr_cnt <= '0;
`else
          state   <= ST_READY;
          ready_q <= 1'b1;
`endif
        end
        ST_CLEAR: begin
          if (clr_cnt == IDX_W'(MEM_DEPTH - 1)) begin
            state   <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state   <= ST_RESET;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // SRAM array: clear writes, lane-masked stores and synchronous reads.
  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
`ifdef RISCV_DATA_MEM_CLEAR_EN
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end
`endif
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) begin
          mem[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_word <= mem[idx];
    end
  end

  // First response stage: remembers how to format the word read this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_load  <= 1'b0;
      p1_err   <= 1'b0;
      p1_off   <= '0;
      p1_size  <= 2'b00;
      p1_uns   <= 1'b0;
    end else begin
      p1_valid <= accept;
      if (accept) begin
        p1_load <= !bus.req_we && !req_err;
        p1_err  <= req_err;
        p1_off  <= off;
        p1_size <= bus.req_size;
        p1_uns  <= bus.req_unsigned;
      end
    end
  end

  assign shifted = rd_word >> {p1_off, 3'b000};

  // Extend the selected lanes to full width; bits above the access size
  // take the fill bit (zero, or the top bit of the loaded value).
  always_comb begin
    int               nbits;
    logic [BIT_W-1:0] top_bit;
    logic             fill;
    nbits = 8 << p1_size;
    if (nbits > DATA_WIDTH) begin
      nbits = DATA_WIDTH;
    end
    top_bit = BIT_W'(nbits - 1);
    fill    = p1_uns ? 1'b0 : shifted[top_bit];
    ext     = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ext[i] = (i < nbits) ? shifted[i] : fill;
    end
  end

  assign load_data = (p1_valid && p1_load) ? ext : '0;
  assign bus.req_ready = ready_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  out_valid;
      logic [DATA_WIDTH-1:0] out_rdata;
      logic                  out_err;

      // Extra output register stage for timing-critical SRAM paths.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out_rdata <= '0;
          out_err   <= 1'b0;
        end else begin
          out_valid <= p1_valid;
          out_rdata <= load_data;
          out_err   <= p1_valid && p1_err;
        end
      end

      assign bus.rsp_valid = out_valid;
      assign bus.rsp_rdata = out_rdata;
      assign bus.rsp_err   = out_err;
    end else begin : g_lat1
      assign bus.rsp_valid = p1_valid;
      assign bus.rsp_rdata = load_data;
      assign bus.rsp_err   = p1_valid && p1_err;
    end
  endgenerate

endmodule

// File: tb/tb_riscv_data_mem.sv
// Bench for riscv_data_mem: drives the same request stream into a
// READ_LATENCY=1 and a READ_LATENCY=2 instance and scores both responses.
module tb_riscv_data_mem;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
`ifdef RISCV_DATA_MEM_CLEAR_EN
  localparam int READY_DELAY = DEPTH + 1;
`else
  localparam int READY_DELAY = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_data_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  riscv_data_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  riscv_data_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .READ_LATENCY(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  riscv_data_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .READ_LATENCY(2))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t q1[$];
  exp_t q2[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void add(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    chk("req_ready_dut1", {63'd0, bus1.req_ready}, 64'd1);
    chk("req_ready_dut2", {63'd0, bus2.req_ready}, 64'd1);
    bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_addr = addr;
    bus1.req_size = size; bus1.req_unsigned = uns; bus1.req_wdata = wdata;
    bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_addr = addr;
    bus2.req_size = size; bus2.req_unsigned = uns; bus2.req_wdata = wdata;
    e.rdata = exp_rdata; e.err = exp_err;
    e.due = cyc + 1; q1.push_back(e);
    e.due = cyc + 2; q2.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus1.req_valid = 1'b0;
    bus2.req_valid = 1'b0;
  endtask

  task automatic check_rsp(input int which, input logic v, input logic [31:0] rd, input logic er);
    exp_t e;
    string tag;
    if (v) begin
      tag = (which == 1) ? "dut1" : "dut2";
      if ((which == 1 && q1.size() == 0) || (which == 2 && q2.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected_%s: got rsp_valid=1 expected no response (cycle %0d)", tag, cyc);
      end else begin
        if (which == 1) e = q1.pop_front();
        else            e = q2.pop_front();
        chk({"rsp_rdata_", tag}, {32'd0, rd}, {32'd0, e.rdata});
        chk({"rsp_err_", tag}, {63'd0, er}, {63'd0, e.err});
        chk({"rsp_cycle_", tag}, 64'(cyc), 64'(e.due));
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready1"}, {63'd0, bus1.req_ready}, 64'd0);
    chk({tag, "_valid1"}, {63'd0, bus1.rsp_valid}, 64'd0);
    chk({tag, "_rdata1"}, {32'd0, bus1.rsp_rdata}, 64'd0);
    chk({tag, "_err1"},   {63'd0, bus1.rsp_err},   64'd0);
    chk({tag, "_ready2"}, {63'd0, bus2.req_ready}, 64'd0);
    chk({tag, "_valid2"}, {63'd0, bus2.rsp_valid}, 64'd0);
    chk({tag, "_rdata2"}, {32'd0, bus2.rsp_rdata}, 64'd0);
    chk({tag, "_err2"},   {63'd0, bus2.rsp_err},   64'd0);
  endtask

  // Release reset mid-cycle and count edges until each instance raises req_ready.
  task automatic release_and_wait(input string tag);
    int n;
    int n1;
    int n2;
    n = 0; n1 = -1; n2 = -1;
    rst_n = 1'b1;
    while ((n1 < 0 || n2 < 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n1 < 0 && bus1.req_ready) n1 = n;
      if (n2 < 0 && bus2.req_ready) n2 = n;
    end
    chk({tag, "_ready_delay1"}, 64'(n1), 64'(READY_DELAY));
    chk({tag, "_ready_delay2"}, 64'(n2), 64'(READY_DELAY));
    if (n1 < 0 || n2 < 0) begin
      $display("FAIL %s_ready_timeout: got no req_ready expected req_ready within 200 cycles", tag);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "req_ready never rose");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ld_exp;

    add(1, 32'h00, 2'b10, 0, 32'h12345678, 32'h0, 0);
    add(0, 32'h00, 2'b10, 0, 32'h0,        32'h12345678, 0);
    add(1, 32'h04, 2'b10, 0, 32'h00000000, 32'h0, 0);
    add(1, 32'h05, 2'b00, 0, 32'h000000AB, 32'h0, 0);
    add(1, 32'h06, 2'b01, 0, 32'h000080FF, 32'h0, 0);
    add(0, 32'h04, 2'b10, 0, 32'h0,        32'h80FFAB00, 0);
    add(0, 32'h05, 2'b00, 0, 32'h0,        32'hFFFFFFAB, 0);
    add(0, 32'h05, 2'b00, 1, 32'h0,        32'h000000AB, 0);
    add(0, 32'h06, 2'b01, 0, 32'h0,        32'hFFFF80FF, 0);
    add(0, 32'h06, 2'b01, 1, 32'h0,        32'h000080FF, 0);
    add(0, 32'h07, 2'b00, 0, 32'h0,        32'hFFFFFF80, 0);
    add(0, 32'h04, 2'b01, 1, 32'h0,        32'h0000AB00, 0);
    add(1, 32'h02, 2'b10, 0, 32'hDEADBEEF, 32'h0, 1);
    add(0, 32'h00, 2'b10, 0, 32'h0,        32'h12345678, 0);
    add(0, 32'h01, 2'b01, 0, 32'h0,        32'h0, 1);
    add(0, 32'h40, 2'b10, 0, 32'h0,        32'h0, 1);
    add(1, 32'h40, 2'b10, 0, 32'hCAFEF00D, 32'h0, 1);
    add(0, 32'h00, 2'b11, 0, 32'h0,        32'h0, 1);
    add(1, 32'h02, 2'b01, 0, 32'h1111BEEF, 32'h0, 0);
    add(0, 32'h00, 2'b10, 0, 32'h0,        32'hBEEF5678, 0);
    add(0, 32'h02, 2'b01, 0, 32'h0,        32'hFFFFBEEF, 0);
    add(1, 32'h3C, 2'b00, 0, 32'h0000005A, 32'h0, 0);
    add(0, 32'h3C, 2'b00, 0, 32'h0,        32'h0000005A, 0);
    add(1, 32'h3F, 2'b00, 0, 32'h000000C3, 32'h0, 0);
    add(0, 32'h3F, 2'b00, 0, 32'h0,        32'hFFFFFFC3, 0);
    add(0, 32'h3F, 2'b00, 1, 32'h0,        32'h000000C3, 0);

    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = '0;
    bus1.req_size = 0; bus1.req_unsigned = 0; bus1.req_wdata = '0;
    bus2.req_valid = 0; bus2.req_we = 0; bus2.req_addr = '0;
    bus2.req_size = 0; bus2.req_unsigned = 0; bus2.req_wdata = '0;

    fork
      forever begin
        @(negedge clk);
        check_rsp(1, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err);
        check_rsp(2, bus2.rsp_valid, bus2.rsp_rdata, bus2.rsp_err);
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    release_and_wait("init");

`ifdef RISCV_DATA_MEM_CLEAR_EN
    drive(0, 32'h3C, 2'b10, 0, 32'h0, 32'h00000000, 0);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
            vecs[i].exp_rdata, vecs[i].exp_err);
    end
    idle();
    @(posedge clk); #1;

    // Throughput: eight stores then eight back-to-back loads.
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'(i * 4), 2'b10, 0, 32'(i + 1) * 32'h11111111, 32'h0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, 32'(i * 4), 2'b10, 0, 32'h0, 32'(i + 1) * 32'h11111111, 0);
    end
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Reset one cycle after a load is accepted: the response must vanish.
    drive(0, 32'h00, 2'b10, 0, 32'h0, 32'h11111111, 0);
    idle();
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    q1.delete();
    q2.delete();
    repeat (3) @(posedge clk);
    #1;
    check_quiet("midreset_hold");
    release_and_wait("rerelease");

`ifdef RISCV_DATA_MEM_CLEAR_EN
    ld_exp = 32'h00000000;
`else
    ld_exp = 32'h22222222;
`endif
    drive(0, 32'h04, 2'b10, 0, 32'h0, ld_exp, 0);
    idle();
    repeat (4) @(posedge clk);
    #1;
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
